// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: frame layout constants and FSM state type for the SPI register interface
package spi_reg_pkg;
    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS = 8;
    localparam int ADDR_FIELD_W = 7;
    localparam logic RW_READ = 1'b1;
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect: rise/fall pulses for an already-synchronized strobe, frozen while en=0
module spi_edge_detect (
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  logic sig,
    output logic rise,
    output logic fall
);
    logic sig_prev;
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sig_prev <= 1'b0;
        else if (en) sig_prev <= sig;
    end
    assign rise = en & sig & ~sig_prev;
    assign fall = en & ~sig & sig_prev;
endmodule

// File: rtl/spi_reg_if.sv
// spi_reg_if: SPI mode-0 16-bit frame decoder driving a small configuration register bank
module spi_reg_if
    import spi_reg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                           clk,
    input  logic                           rstb,
    input  logic                           en,
    input  logic                           sclk_sync,
    input  logic                           cs_n_sync,
    input  logic                           mosi_sync,
    output logic                           miso,
    output logic                           miso_oe,
    output logic [(2**ADDR_W)*DATA_W-1:0]  regs_out,
    output logic                           wr_strobe,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic                           frame_err
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [FRAME_BITS-2:0] sr;
    logic [FRAME_BITS-1:0] nxt;
    logic [DATA_W-1:0] shift_out;
    logic [ADDR_FIELD_W-1:0] addr_f;
    logic [ADDR_W-1:0] idx;
    logic rw, valid, rise, fall, last_cmd, last_bit;
    int ofs;
    spi_edge_detect u_sclk_edge (
        .clk  (clk),
        .rstb (rstb),
        .en   (en),
        .sig  (sclk_sync),
        .rise (rise),
        .fall (fall)
    );
    // command fields come from the incoming bit on the 8th rise, or from the shifted-in frame on the 16th
    always_comb begin
        nxt = {sr, mosi_sync};
        last_cmd = cnt == CNT_W'(CMD_BITS - 1);
        last_bit = cnt == CNT_W'(FRAME_BITS - 1);
        rw = last_cmd ? nxt[CMD_BITS-1] : nxt[FRAME_BITS-1];
        addr_f = last_cmd ? nxt[ADDR_FIELD_W-1:0] : nxt[FRAME_BITS-2 -: ADDR_FIELD_W];
        idx = addr_f[ADDR_W-1:0];
        valid = (addr_f >> ADDR_W) == '0;
        ofs = int'(idx) * DATA_W;
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            shift_out <= '0;
            regs_out <= '0;
            miso <= 1'b0;
            miso_oe <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr <= '0;
            frame_err <= 1'b0;
        end else if (!en) begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            miso_oe <= ~cs_n_sync;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (cs_n_sync) begin
                state <= IDLE;
                cnt <= '0;
                miso <= 1'b0;
                frame_err <= cnt != '0 && cnt != CNT_W'(FRAME_BITS);
            end else begin
                case (state)
                    IDLE: state <= CMD;
                    CMD: if (rise) begin
                        sr <= nxt[FRAME_BITS-2:0];
                        cnt <= cnt + 1'b1;
                        if (last_cmd) begin
                            state <= DATA;
                            shift_out <= (rw == RW_READ && valid) ? regs_out[ofs +: DATA_W] : '0;
                        end
                    end
                    DATA: if (rise) begin
                        sr <= nxt[FRAME_BITS-2:0];
                        cnt <= cnt + 1'b1;
                        if (last_bit) begin
                            state <= DONE;
                            if (rw != RW_READ && valid) begin
                                regs_out[ofs +: DATA_W] <= nxt[DATA_W-1:0];
                                wr_strobe <= 1'b1;
                                wr_addr <= idx;
                            end
                        end
                    end else if (fall) begin
                        miso <= shift_out[DATA_W-1];
                        shift_out <= shift_out << 1;
                    end
                    DONE: if (fall) miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_if.sv
// tb_spi_reg_if: randomized SPI frames checked every cycle against a frame-level register model
module tb_spi_reg_if;
    logic clk = 0, rstb = 0, en = 1, sclk = 0, cs_n = 1, mosi = 0;
    logic miso, miso_oe, wr_strobe, frame_err;
    logic [63:0] regs_out;
    logic [2:0] wr_addr;
    int tests = 0, fails = 0;
    logic [7:0] mreg [8];
    logic exp_wr = 0, exp_err = 0, exp_miso = 0, exp_oe = 0;
    logic [2:0] exp_addr = 0;
    logic [7:0] got;
    always #5 clk = ~clk;
    spi_reg_if dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .sclk_sync (sclk),
        .cs_n_sync (cs_n),
        .mosi_sync (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    function automatic logic [63:0] flat();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = mreg[i];
        return r;
    endfunction
    task automatic zero_model();
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        exp_wr = 0; exp_err = 0; exp_miso = 0; exp_addr = 0;
    endtask
    always @(posedge clk or negedge rstb)
        if (!rstb) exp_oe <= 1'b0;
        else if (en) exp_oe <= ~cs_n;
    always @(negedge clk) begin
        chk("regs_out", regs_out, flat());
        chk("wr_strobe", wr_strobe, exp_wr);
        chk("wr_addr", wr_addr, exp_addr);
        chk("frame_err", frame_err, exp_err);
        chk("miso", miso, exp_miso);
        chk("miso_oe", miso_oe, exp_oe);
    end
    task automatic frame(input logic [15:0] f, input int nb, input int rst_at);
        logic [7:0] rd;
        logic ok;
        ok = f[14:8] < 7'd8;
        rd = 0;
        got = 0;
        cs_n = 0;
        mosi = f[15];
        repeat (4) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            sclk = 1;
            @(posedge clk); #1;
            if (en && i == 7) rd = (f[15] && ok) ? mreg[f[10:8]] : 8'h00;
            if (en && i == 15 && !f[15] && ok) begin
                mreg[f[10:8]] = f[7:0];
                exp_wr = 1;
                exp_addr = f[10:8];
            end
            if (rst_at == i + 1) begin
                #1 rstb = 0;
                zero_model();
                @(negedge clk);
                cs_n = 1; sclk = 0;
                repeat (3) @(negedge clk);
                rstb = 1;
                repeat (2) @(negedge clk);
                return;
            end
            @(posedge clk); #1 exp_wr = 0;
            repeat (3) @(negedge clk);
            sclk = 0;
            if (i < 15) mosi = f[14-i];
            @(posedge clk); #1;
            if (en) exp_miso = (i >= 7 && i <= 14) ? rd[14-i] : 1'b0;
            if (i >= 7 && i <= 14) got[14-i] = miso;
            repeat (4) @(negedge clk);
        end
        cs_n = 1;
        @(posedge clk); #1;
        if (en) begin
            exp_err = nb != 0 && nb != 16;
            exp_miso = 0;
        end
        @(posedge clk); #1 exp_err = 0;
        @(negedge clk);
    endtask
    initial begin
        logic [15:0] f;
        int nb;
        zero_model();
        repeat (3) @(negedge clk);
        rstb = 1;
        @(negedge clk);
        frame(16'h0312, 16, 0);
        chk("lit_wr3", regs_out, 64'h00000000_12000000);
        chk("lit_model3", mreg[3], 8'h12);
        frame(16'h8300, 16, 0);
        chk("lit_rd3", got, 8'h12);
        frame(16'h2A55, 16, 0);
        chk("lit_badwr", regs_out, 64'h00000000_12000000);
        frame(16'hAA00, 16, 0);
        chk("lit_badrd", got, 8'h00);
        frame(16'h01AB, 11, 0);
        chk("lit_abort", regs_out[15:8], 8'h00);
        frame(16'h01FF, 16, 0);
        chk("lit_wr1", regs_out[15:8], 8'hFF);
        en = 0;
        frame(16'h0555, 16, 0);
        chk("lit_en0", regs_out[47:40], 8'h00);
        en = 1;
        frame(16'h0555, 16, 0);
        chk("lit_en1", regs_out[47:40], 8'h55);
        frame(16'h8300, 16, 12);
        chk("lit_rst", regs_out, 64'h0);
        frame(16'h0701, 16, 0);
        chk("lit_wr7", regs_out[63:56], 8'h01);
        repeat (60) begin
            f = 16'($urandom);
            if ($urandom_range(0, 3) != 0) f[14:11] = 4'h0;
            nb = $urandom_range(0, 3) != 0 ? 16 : int'($urandom_range(0, 15));
            en = $urandom_range(0, 9) != 0;
            frame(f, nb, 0);
        end
        en = 1;
        frame(16'h8700, 16, 0);
        frame(16'h8300, 16, 0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
